// File: rtl/mult_seq_pkg.sv
// mult_seq_pkg: shared state encodings for the sequential multiplier
package mult_seq_pkg;
    localparam logic [1:0] MULT_IDLE = 2'd0;
    localparam logic [1:0] MULT_CALC = 2'd1;
    localparam logic [1:0] MULT_FIX  = 2'd2;
    localparam logic [1:0] MULT_DONE = 2'd3;
endpackage

// File: rtl/mult_seq_cla.sv
// mult_seq_cla: N-bit carry-look-ahead adder (4-bit lookahead groups), mode 1 subtracts
module mult_seq_cla #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         mode,
    output logic [N-1:0] sum,
    output logic         carry
);
    logic [N-1:0] bv, g, p;
    logic [N:0]   c;
    if (N != 4 && N != 16 && N != 32) begin : g_bad_n
        $error("mult_seq_cla: unsupported width N=%0d (legal: 4, 16, 32)", N);
    end
    assign bv = b ^ {N{mode}};
    assign g = a & bv;
    assign p = a ^ bv;
    // carries expanded within each 4-bit group, group carry chained to the next group
    always_comb begin
        c = '0;
        c[0] = mode;
        for (int j = 0; j < N / 4; j++) begin
            c[4*j+1] = g[4*j] | (p[4*j] & c[4*j]);
            c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & c[4*j]);
            c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
                     | (p[4*j+2] & p[4*j+1] & p[4*j] & c[4*j]);
            c[4*j+4] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                     | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j])
                     | (p[4*j+3] & p[4*j+2] & p[4*j+1] & p[4*j] & c[4*j]);
        end
    end
    assign sum = p ^ c[N-1:0];
    assign carry = c[N];
endmodule

// File: rtl/mult_seq.sv
// mult_seq: iterative shift-and-add multiplier, signed/unsigned, valid/ready on both sides
module mult_seq
    import mult_seq_pkg::*;
#(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    input  logic           sign_mode,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] product,
    output logic           busy
);
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    logic [1:0]    state;
    logic [N-1:0]  acc_hi, mplier, mcand, sum;
    logic [CW-1:0] cnt;
    logic          neg, c;
    if (N != 4 && N != 16 && N != 32) begin : g_bad_n
        $error("mult_seq: unsupported width N=%0d (legal: 4, 16, 32)", N);
    end
    assign in_ready = state == MULT_IDLE;
    assign out_valid = state == MULT_DONE;
    assign busy = state == MULT_CALC || state == MULT_FIX;
    mult_seq_cla #(.N(N)) u_cla (
        .a(acc_hi),
        .b(mplier[0] ? mcand : '0),
        .mode(1'b0),
        .sum(sum),
        .carry(c)
    );
    // operand capture on accept, one partial sum per CALC cycle, sign fix-up, output hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= MULT_IDLE;
            acc_hi <= '0;
            mplier <= '0;
            mcand <= '0;
            cnt <= '0;
            neg <= 1'b0;
            product <= '0;
        end else if (state == MULT_IDLE) begin
            if (in_valid) begin
                neg <= sign_mode & (a[N-1] ^ b[N-1]);
                mcand <= (sign_mode && a[N-1]) ? ~a + 1'b1 : a;
                mplier <= (sign_mode && b[N-1]) ? ~b + 1'b1 : b;
                acc_hi <= '0;
                cnt <= '0;
                state <= MULT_CALC;
            end
        end else if (state == MULT_CALC) begin
            {acc_hi, mplier} <= {c, sum, mplier[N-1:1]};
            cnt <= cnt + 1'b1;
            state <= cnt == LAST ? MULT_FIX : MULT_CALC;
        end else if (state == MULT_FIX) begin
            product <= neg ? ~{acc_hi, mplier} + 1'b1 : {acc_hi, mplier};
            state <= MULT_DONE;
        end else if (out_ready) begin
            state <= MULT_IDLE;
        end
    end
endmodule

// File: tb/tb_mult_seq.sv
// tb_mult_seq: directed vector bench for mult_seq at N=32 plus an N=4 build
module tb_mult_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iv = 1'b0, ir, sm = 1'b0, ov, ordy = 1'b0, bz;
    logic [31:0] a = '0, b = '0;
    logic [63:0] prod;
    logic        iv4 = 1'b0, ir4, sm4 = 1'b0, ov4, ordy4 = 1'b0, bz4;
    logic [3:0]  a4 = '0, b4 = '0;
    logic [7:0]  prod4;
    int tests = 0, fails = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [63:0] p;
    } vec_t;
    vec_t v[10];

    always #5 clk = ~clk;

    mult_seq #(.N(32)) dut (
        .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .a(a), .b(b),
        .sign_mode(sm), .out_valid(ov), .out_ready(ordy), .product(prod), .busy(bz)
    );

    mult_seq #(.N(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
        .sign_mode(sm4), .out_valid(ov4), .out_ready(ordy4), .product(prod4), .busy(bz4)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic wait_ov(output int cyc);
        cyc = 0;
        while (!ov && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic s,
                          input logic [63:0] exp, input string name);
        int cyc;
        iv = 1'b1; a = x; b = y; sm = s;
        @(posedge clk); #1;
        iv = 1'b0; a = ~x; b = ~y; sm = ~s;
        wait_ov(cyc);
        chk({name, " latency"}, 64'(cyc), 64'd33);
        chk(name, prod, exp);
        ordy = 1'b1;
        @(posedge clk); #1;
        ordy = 1'b0;
        chk({name, " in_ready after handshake"}, {63'd0, ir}, 64'd1);
    endtask

    task automatic run_op4(input logic [3:0] x, input logic [3:0] y, input logic s,
                           input logic [7:0] exp, input string name);
        int cyc;
        iv4 = 1'b1; a4 = x; b4 = y; sm4 = s;
        @(posedge clk); #1;
        iv4 = 1'b0;
        cyc = 0;
        while (!ov4 && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({name, " latency"}, 64'(cyc), 64'd5);
        chk(name, {56'd0, prod4}, {56'd0, exp});
        ordy4 = 1'b1;
        @(posedge clk); #1;
        ordy4 = 1'b0;
    endtask

    initial begin
        int cyc;
        logic stable;
        v[0] = '{32'd3, 32'd5, 1'b0, 64'h0000_0000_0000_000F};
        v[1] = '{32'hFFFF_FFF9, 32'd6, 1'b1, 64'hFFFF_FFFF_FFFF_FFD6};
        v[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001};
        v[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001};
        v[4] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000};
        v[5] = '{32'h8000_0000, 32'd1, 1'b1, 64'hFFFF_FFFF_8000_0000};
        v[6] = '{32'd0, 32'h1234_5678, 1'b0, 64'd0};
        v[7] = '{32'd7, 32'hFFFF_FFFE, 1'b1, 64'hFFFF_FFFF_FFFF_FFF2};
        v[8] = '{32'h8000_0000, 32'd2, 1'b0, 64'h0000_0001_0000_0000};
        v[9] = '{32'h0001_0000, 32'h0001_0000, 1'b0, 64'h0000_0001_0000_0000};

        @(posedge clk); #1;
        chk("reset in_ready", {63'd0, ir}, 64'd1);
        chk("reset out_valid", {63'd0, ov}, 64'd0);
        chk("reset busy", {63'd0, bz}, 64'd0);
        chk("reset product", prod, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++)
            run_op(v[i].a, v[i].b, v[i].s, v[i].p, $sformatf("vec%0d", i));

        // backpressure: hold out_ready low for 10 cycles in DONE
        iv = 1'b1; a = 32'd6; b = 32'd7; sm = 1'b0;
        @(posedge clk); #1;
        iv = 1'b0;
        chk("bp busy in calc", {63'd0, bz}, 64'd1);
        chk("bp in_ready in calc", {63'd0, ir}, 64'd0);
        wait_ov(cyc);
        chk("bp latency", 64'(cyc), 64'd33);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (!ov || ir || bz || prod !== 64'd42) stable = 1'b0;
            @(posedge clk); #1;
        end
        chk("bp hold stable", {63'd0, stable}, 64'd1);
        ordy = 1'b1;
        @(posedge clk); #1;
        ordy = 1'b0;
        chk("bp out_valid drops", {63'd0, ov}, 64'd0);
        chk("bp in_ready rises", {63'd0, ir}, 64'd1);

        // back-to-back with in_valid held high; operand change during CALC is ignored
        iv = 1'b1; a = 32'd9; b = 32'd9;
        @(posedge clk); #1;
        a = 32'd10; b = 32'd11;
        wait_ov(cyc);
        chk("b2b first", prod, 64'd81);
        ordy = 1'b1;
        @(posedge clk); #1;
        ordy = 1'b0;
        chk("b2b idle in_ready", {63'd0, ir}, 64'd1);
        @(posedge clk); #1;
        iv = 1'b0;
        chk("b2b second accepted", {63'd0, bz}, 64'd1);
        wait_ov(cyc);
        chk("b2b second latency", 64'(cyc), 64'd33);
        chk("b2b second", prod, 64'd110);
        ordy = 1'b1;
        @(posedge clk); #1;
        ordy = 1'b0;

        // asynchronous reset mid-CALC
        iv = 1'b1; a = 32'd123; b = 32'd456;
        @(posedge clk); #1;
        iv = 1'b0;
        repeat (12) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async rst out_valid", {63'd0, ov}, 64'd0);
        chk("async rst product", prod, 64'd0);
        chk("async rst in_ready", {63'd0, ir}, 64'd1);
        chk("async rst busy", {63'd0, bz}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_op(32'd2, 32'd2, 1'b0, 64'd4, "after reset 2x2");

        run_op4(4'd15, 4'd15, 1'b0, 8'hE1, "n4 15x15");
        run_op4(4'h8, 4'h8, 1'b1, 8'h40, "n4 -8x-8");
        run_op4(4'd7, 4'hF, 1'b1, 8'hF9, "n4 7x-1");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
